// File: rtl/i2s_master_tx16_pkg.sv
// Shared constants and types for the 16-bit I2S transmit master.
package i2s_pkg;

    localparam int I2S_SLOT_BITS  = 16;
    localparam int I2S_FRAME_BITS = 32;
    localparam int TF_HIGH_FIRST  = 15;
    localparam int TF_HIGH_LAST   = 30;
    localparam int POS_BITS       = $clog2(I2S_FRAME_BITS);

    // Left sample occupies the upper half so the packed pair is the frame word.
    typedef struct packed {
        logic [I2S_SLOT_BITS-1:0] l;
        logic [I2S_SLOT_BITS-1:0] r;
    } i2s_pair_t;

    // Word select is high one bit early for the right slot and drops one bit
    // early for the next left slot.
    function automatic logic tf_for_pos(input logic [POS_BITS-1:0] pos);
        return (pos >= POS_BITS'(TF_HIGH_FIRST)) && (pos <= POS_BITS'(TF_HIGH_LAST));
    endfunction

endpackage

// File: rtl/i2s_master_tx16_if.sv
// Sample-pair handshake between the fabric producer and the I2S transmitter.
interface i2s_master_tx16_if;
    import i2s_pkg::*;

    logic [I2S_SLOT_BITS-1:0] in_L;
    logic [I2S_SLOT_BITS-1:0] in_R;
    logic                     in_valid;
    logic                     in_ready;

    modport master (output in_L, output in_R, output in_valid, input in_ready);
    modport slave  (input in_L, input in_R, input in_valid, output in_ready);

endinterface

// File: rtl/i2s_master_tx16_bck_gen.sv
// Bit-clock generator: TK toggles every BCK_DIV cycles of clk_25.
// fall_evt is high in the cycle whose closing edge drives TK from 1 to 0,
// so registers updated on fall_evt change together with TK.
module i2s_bck_gen #(
    parameter int BCK_DIV = 8
) (
    input  logic clk_25,
    input  logic rst,
    output logic tk,
    output logic fall_evt
);

    localparam int CW = $clog2(BCK_DIV);

    logic [CW-1:0] div_cnt;
    logic          tc;

    assign tc       = (div_cnt == CW'(BCK_DIV - 1));
    assign fall_evt = tc & tk;

    // Half-period divider; TK toggles and the divider wraps at terminal count.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            div_cnt <= '0;
            tk      <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            tk      <= ~tk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2s_master_tx16.sv
// I2S transmit master: one-entry holding register feeding a 32-bit frame
// shifter, with frame position, word select and load/underrun pulses.
module i2s_master_tx16
    import i2s_pkg::*;
#(
    parameter int BCK_DIV = 8
) (
    input  logic              clk_25,
    input  logic              rst,
    i2s_master_tx16_if.slave  smp,
    output logic              I2S_TK,
    output logic              I2S_TF,
    output logic              I2S_TD,
    output logic              frame_start,
    output logic              underrun
);

    logic                      fall_evt;
    logic [POS_BITS-1:0]       pos;
    logic [POS_BITS-1:0]       pos_nxt;
    logic [I2S_FRAME_BITS-1:0] shreg;
    logic [I2S_FRAME_BITS-1:0] load_word;
    i2s_pair_t                 hold;
    logic                      hold_full;
    logic                      accept;
    logic                      load;

    i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
        .clk_25   (clk_25),
        .rst      (rst),
        .tk       (I2S_TK),
        .fall_evt (fall_evt)
    );

    assign smp.in_ready = ~hold_full;
    assign accept       = smp.in_valid & ~hold_full;
    assign pos_nxt      = pos + POS_BITS'(1);
    assign load         = fall_evt & (pos == POS_BITS'(I2S_FRAME_BITS - 1));
    // An empty holding register sends a silent frame; no bypass from the input.
    assign load_word    = hold_full ? hold : '0;

    // Holding register: filled on accept, emptied when a frame is loaded.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= '{l: smp.in_L, r: smp.in_R};
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Frame position, serial data, word select and pulses advance on TK falls.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            pos         <= POS_BITS'(I2S_FRAME_BITS - 1);
            shreg       <= '0;
            I2S_TD      <= 1'b0;
            I2S_TF      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (fall_evt) begin
                pos    <= pos_nxt;
                I2S_TF <= tf_for_pos(pos_nxt);
                if (load) begin
                    frame_start <= 1'b1;
                    underrun    <= ~hold_full;
                    I2S_TD      <= load_word[I2S_FRAME_BITS-1];
                    shreg       <= {load_word[I2S_FRAME_BITS-2:0], 1'b0};
                end else begin
                    I2S_TD      <= shreg[I2S_FRAME_BITS-1];
                    shreg       <= {shreg[I2S_FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_master_tx16.sv
// Bench for i2s_master_tx16: default and BCK_DIV=2 builds driven in parallel,
// checked every cycle against an arithmetic timing model, plus a table of
// single-pair scenarios decoded by a TK-rising-edge receiver.
module tb_i2s_master_tx16;

    logic        clk_25;
    logic        rst;
    logic [15:0] in_l, in_r;
    logic        in_valid;

    logic tk_a, tf_a, td_a, fs_a, ur_a;
    logic tk_b, tf_b, td_b, fs_b, ur_b;

    i2s_master_tx16_if if_a();
    i2s_master_tx16_if if_b();

    assign if_a.in_L = in_l;  assign if_a.in_R = in_r;  assign if_a.in_valid = in_valid;
    assign if_b.in_L = in_l;  assign if_b.in_R = in_r;  assign if_b.in_valid = in_valid;

    i2s_master_tx16 #(.BCK_DIV(8)) dut_a (
        .clk_25(clk_25), .rst(rst), .smp(if_a),
        .I2S_TK(tk_a), .I2S_TF(tf_a), .I2S_TD(td_a),
        .frame_start(fs_a), .underrun(ur_a)
    );

    i2s_master_tx16 #(.BCK_DIV(2)) dut_b (
        .clk_25(clk_25), .rst(rst), .smp(if_b),
        .I2S_TK(tk_b), .I2S_TF(tf_b), .I2S_TD(td_b),
        .frame_start(fs_b), .underrun(ur_b)
    );

    initial begin
        clk_25 = 1'b0;
        forever #20 clk_25 = ~clk_25;
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference model: k counts cycles since reset release; TK and falling
    // events follow from k by division, the hold is a single-slot mailbox.
    int          dv[2] = '{8, 2};
    int          k[2];
    int          p[2];
    bit          held[2];
    logic [31:0] hval[2];
    logic [31:0] w[2];
    bit          m_fs[2];
    bit          m_ur[2];

    // Receiver on DUT A: captures TD on TK rising edges after each frame_start.
    logic [31:0] rx_q[$];
    bit          ur_q[$];
    logic [31:0] rx_w;
    int          rx_n;
    bit          rx_on;
    logic        prev_tk;
    int          first_rise, first_fs;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          a;
        logic [31:0] w0;
        bit          ur0;
        logic [31:0] w1;
        bit          ur1;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int i, input bit r, input bit v, input logic [31:0] d);
        bit acc;
        if (r) begin
            k[i] = 0; p[i] = 31; held[i] = 0; w[i] = '0; m_fs[i] = 0; m_ur[i] = 0;
            return;
        end
        acc     = v && !held[i];
        k[i]    = k[i] + 1;
        m_fs[i] = 0;
        m_ur[i] = 0;
        if (k[i] % (2 * dv[i]) == 0) begin
            p[i] = (p[i] + 1) % 32;
            if (p[i] == 0) begin
                m_fs[i] = 1;
                if (held[i]) begin
                    w[i] = hval[i]; held[i] = 0;
                end else begin
                    w[i] = '0; m_ur[i] = 1;
                end
            end
        end
        if (acc) begin
            held[i] = 1; hval[i] = d;
        end
    endtask

    function automatic logic [5:0] exp_vec(input int i);
        logic tkv, tfv, tdv;
        tkv = ((k[i] / dv[i]) % 2) == 1;
        tfv = (p[i] >= 15) && (p[i] <= 30);
        tdv = w[i][31 - p[i]];
        return {tkv, tfv, tdv, m_fs[i], m_ur[i], ~held[i]};
    endfunction

    task automatic step();
        bit          r, v;
        logic [31:0] d;
        r = rst; v = in_valid; d = {in_l, in_r};
        @(posedge clk_25);
        #1;
        for (int i = 0; i < 2; i++) model_edge(i, r, v, d);
        chk("out_a", {26'd0, tk_a, tf_a, td_a, fs_a, ur_a, if_a.in_ready}, {26'd0, exp_vec(0)});
        chk("out_b", {26'd0, tk_b, tf_b, td_b, fs_b, ur_b, if_b.in_ready}, {26'd0, exp_vec(1)});
        if (r) begin
            rx_on = 0; prev_tk = 0; first_rise = -1; first_fs = -1;
        end else begin
            if (fs_a) begin
                rx_on = 1; rx_n = 0; ur_q.push_back(ur_a);
                if (first_fs < 0) first_fs = k[0];
            end
            if (tk_a && !prev_tk) begin
                if (first_rise < 0) first_rise = k[0];
                if (rx_on) begin
                    rx_w = {rx_w[30:0], td_a};
                    rx_n++;
                    if (rx_n == 32) begin
                        rx_q.push_back(rx_w); rx_on = 0;
                    end
                end
            end
            prev_tk = tk_a;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        rx_q.delete(); ur_q.delete();
    endtask

    initial begin
        int          cnt, c, n_ur;
        bit          acc, found;

        tbl[0] = '{16'hA5C3, 16'h0F0F,  1, 32'hA5C30F0F, 1'b0, 32'h0,        1'b1};
        tbl[1] = '{16'h8000, 16'h7FFF, 15, 32'h80007FFF, 1'b0, 32'h0,        1'b1};
        tbl[2] = '{16'h1234, 16'h5678, 16, 32'h0,        1'b1, 32'h12345678, 1'b0};
        tbl[3] = '{16'hFFFF, 16'h0000, 17, 32'h0,        1'b1, 32'hFFFF0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_l = '0; in_r = '0;
        rx_w = '0; rx_n = 0; rx_on = 0; prev_tk = 0; first_rise = -1; first_fs = -1;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; p[i] = 31; held[i] = 0; w[i] = '0; hval[i] = '0; m_fs[i] = 0; m_ur[i] = 0;
        end

        // Reset state and idle frames.
        step(); step(); step();
        chk("reset_vec", {26'd0, tk_a, tf_a, td_a, fs_a, ur_a, if_a.in_ready}, 32'h1);
        rst = 1'b0;
        rx_q.delete(); ur_q.delete();
        repeat (1045) step();
        chk("idle_first_rise", first_rise, 8);
        chk("idle_first_fs", first_fs, 16);
        chk("idle_rx_count", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            chk("idle_word0", rx_q[0], 32'h0);
            chk("idle_word1", rx_q[1], 32'h0);
        end
        if (ur_q.size() >= 2) begin
            chk("idle_ur0", ur_q[0], 1);
            chk("idle_ur1", ur_q[1], 1);
        end

        // Single-pair scenarios around the first load.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            for (int e = 1; e < tbl[t].a; e++) step();
            in_l = tbl[t].l; in_r = tbl[t].r; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            for (int e = tbl[t].a; e < 1045; e++) step();
            chk("tbl_rx_count", rx_q.size(), 2);
            chk("tbl_ur_count", ur_q.size(), 3);
            if (rx_q.size() >= 2 && ur_q.size() >= 2) begin
                chk("tbl_word0", rx_q[0], tbl[t].w0);
                chk("tbl_ur0",   ur_q[0], tbl[t].ur0);
                chk("tbl_word1", rx_q[1], tbl[t].w1);
                chk("tbl_ur1",   ur_q[1], tbl[t].ur1);
            end
        end

        // Continuous stream, valid held high, incrementing data.
        do_reset();
        cnt = 0;
        in_valid = 1'b1;
        in_l = 16'h1000; in_r = 16'hF000;
        repeat (4112) begin
            acc = !held[0];
            step();
            if (acc) begin
                cnt++;
                in_l = 16'h1000 + 16'(cnt);
                in_r = 16'hF000 - 16'(cnt);
            end
        end
        chk("stream_rx_count", rx_q.size(), 8);
        for (int j = 0; j < 8 && j < rx_q.size(); j++)
            chk("stream_word", rx_q[j], {16'h1000 + 16'(j), 16'hF000 - 16'(j)});
        n_ur = 0;
        foreach (ur_q[j]) n_ur += ur_q[j];
        chk("stream_underruns", n_ur, 0);

        // Sparse random producer.
        do_reset();
        repeat (4000) begin
            in_valid = ($urandom_range(0, 99) < 3);
            in_l = 16'($urandom); in_r = 16'($urandom);
            step();
        end

        // Reset mid-frame with hold full.
        in_valid = 1'b1;
        found = 0;
        c = 0;
        while (!found && c < 2000) begin
            in_l = 16'($urandom); in_r = 16'($urandom);
            step();
            c++;
            if (p[0] == 20 && held[0]) found = 1;
        end
        chk("midrst_reached", found, 1);
        chk("midrst_pre_ready", if_a.in_ready, 0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("midrst_vec", {26'd0, tk_a, tf_a, td_a, fs_a, ur_a, if_a.in_ready}, 32'h1);
        rst = 1'b0;
        c = 0;
        found = 0;
        while (!found && c < 100) begin
            step();
            c++;
            if (fs_a) found = 1;
        end
        chk("midrst_load_delay", c, 16);
        chk("midrst_load_ur", ur_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
